// File: rtl/timer_share_pkg.sv
// Shared types and timer register map for the timer-sharing arbiter.
package timer_share_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WR_STOP,
        ST_WR_PL,
        ST_WR_PH,
        ST_GAP,
        ST_WR_START,
        ST_WAIT,
        ST_CLR,
        ST_DIS,
        ST_FIN
    } state_e;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;

    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [15:0] CTRL_STOP      = 16'(1) << CTRL_STOP_BIT;
    localparam logic [15:0] CTRL_START_ITO = (16'(1) << CTRL_START_BIT) | (16'(1) << CTRL_ITO_BIT);
    localparam logic [15:0] STATUS_CLEAR   = 16'h0000;

    // A zero load value leaves the timer's behaviour undefined, so pace with 1 instead.
    function automatic logic [31:0] load_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts one past the last winner; the pointer moves only on advance.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;

    // Walk from the far end so the candidate closest to ptr_q is assigned last and wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (req_i[cand]) begin
                gnt_o   = N'(1) << cand;
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && valid_o) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/timer_share_arbiter.sv
// Shares one interval timer among N_REQ clients: programs a one-shot per job,
// waits for the timeout irq, clears and stops the timer, then pulses done.
module timer_share_arbiter
    import timer_share_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int PERIOD_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PERIOD_W-1:0] req_period,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [2:0]                tmr_address,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    done_q;
    logic                busy_q;
    logic                abort_q;
    logic [31:0]         period_q;
    logic                cs_q;
    logic [2:0]          addr_q;
    logic [15:0]         wdata_q;

    logic [N_REQ-1:0]    req_eff;
    logic [N_REQ-1:0]    arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;
    logic                owner_req;
    logic [PERIOD_W-1:0] per_sel;

    // The owner still holds req during its done cycle; keep it out of that decision.
    assign req_eff   = req & ~done_q;
    assign owner_req = |(req & grant_q);

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .req_i     (req_eff),
        .advance_i (state_q == ST_IDLE),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    always_comb begin
        per_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                per_sel = req_period[i*PERIOD_W +: PERIOD_W];
            end
        end
    end

    // Each write is set up on the transition into its state, so the bus
    // cycle and the state that names it line up exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
            period_q <= '0;
            cs_q     <= 1'b0;
            addr_q   <= ADDR_STATUS;
            wdata_q  <= '0;
        end else begin
            cs_q    <= 1'b0;
            addr_q  <= ADDR_STATUS;
            wdata_q <= '0;
            done_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q  <= arb_gnt;
                        busy_q   <= 1'b1;
                        abort_q  <= 1'b0;
                        period_q <= load_period(per_sel);
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_CONTROL;
                    wdata_q <= CTRL_STOP;
                    state_q <= ST_WR_STOP;
                end
                ST_WR_STOP: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_PERIODL;
                    wdata_q <= period_q[15:0];
                    state_q <= ST_WR_PL;
                end
                ST_WR_PL: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_PERIODH;
                    wdata_q <= period_q[31:16];
                    state_q <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_CONTROL;
                    wdata_q <= CTRL_START_ITO;
                    state_q <= ST_WR_START;
                end
                ST_WR_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A dropped request wins over a simultaneous irq: the job is abandoned.
                    if (!owner_req || tmr_irq) begin
                        abort_q <= !owner_req;
                        cs_q    <= 1'b1;
                        addr_q  <= ADDR_STATUS;
                        wdata_q <= STATUS_CLEAR;
                        state_q <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    cs_q    <= 1'b1;
                    addr_q  <= ADDR_CONTROL;
                    wdata_q <= CTRL_STOP;
                    state_q <= ST_DIS;
                end
                ST_DIS: begin
                    state_q <= ST_FIN;
                end
                ST_FIN: begin
                    if (!abort_q) begin
                        done_q <= grant_q;
                    end
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = ~cs_q;
    assign tmr_address    = addr_q;
    assign tmr_writedata  = wdata_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));
    a_busy_grant:   assert property (@(posedge clk) disable iff (!reset_n) busy_q == (|grant_q));
    a_done_onehot:  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(done_q));

endmodule
